// File: rtl/read_id_gate_pkg.sv
// read_id_gate_pkg: shared read-path types and default widths for the
// read ID admission gate and its scoreboard.
package read_id_gate_pkg;

  localparam int unsigned DEFAULT_ID_WIDTH   = 4;
  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_ID_COUNT   = 2 ** DEFAULT_ID_WIDTH;

  typedef logic [DEFAULT_ID_WIDTH-1:0]   id_t;
  typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;

  // One-hot mask selecting a single ID in the busy bitmap.
  function automatic logic [DEFAULT_ID_COUNT-1:0] id_onehot(input id_t id);
    logic [DEFAULT_ID_COUNT-1:0] mask;
    mask     = '0;
    mask[id] = 1'b1;
    return mask;
  endfunction

endpackage : read_id_gate_pkg

// File: rtl/read_id_gate_id_scoreboard.sv
// id_scoreboard: tracks which read IDs are in flight, how many reads are
// outstanding, and (with READ_ID_GATE_ERR_EN defined) a sticky protocol
// error flag for releases of IDs that were never claimed.
module id_scoreboard
  import read_id_gate_pkg::*;
#(
  parameter int unsigned ID_WIDTH        = DEFAULT_ID_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = 8,
  localparam int unsigned ID_COUNT       = 2 ** ID_WIDTH,
  localparam int unsigned CNT_WIDTH      = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_i,
  input  logic [ID_WIDTH-1:0]  set_id_i,
  input  logic                 clr_i,
  input  logic [ID_WIDTH-1:0]  clr_id_i,
  output logic [ID_COUNT-1:0]  busy_o,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 room_c,
  output logic                 err_o
);

  logic [ID_COUNT-1:0]  busy_q;
  logic [ID_COUNT-1:0]  busy_d;
  logic [ID_COUNT-1:0]  set_mask;
  logic [ID_COUNT-1:0]  clr_mask;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  // Decode the claim and release strobes into bitmap masks.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_i) set_mask[set_id_i] = 1'b1;
    if (clr_i) clr_mask[clr_id_i] = 1'b1;
  end

  // Next bitmap: release first, then claim, so a fresh claim is never lost.
  always_comb begin
    busy_d = (busy_q & ~clr_mask) | set_mask;
  end

  // Next count: a simultaneous claim and release cancel; release saturates at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (set_i && !clr_i) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else if (!set_i && clr_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end
  end

  // Bitmap and counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef READ_ID_GATE_ERR_EN
  logic err_q;
  logic err_d;

  // Flag a release of an ID that is not in flight, or a release at zero count.
  always_comb begin
    err_d = err_q;
    if (clr_i && (!busy_q[clr_id_i] || ((cnt_q == '0) && !set_i))) begin
      err_d = 1'b1;
    end
  end

  // Sticky error register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign busy_o  = busy_q;
  assign count_o = cnt_q;
  assign room_c  = (cnt_q < CNT_WIDTH'(MAX_OUTSTANDING));

endmodule : id_scoreboard

// File: rtl/read_id_gate.sv
// read_id_gate: admission stage ahead of the read reorder buffer. Allows at
// most one outstanding read per ID and MAX_OUTSTANDING reads in total.
// AR is registered through a one-entry holding register; R passes straight
// through and releases its ID on handshake.
// Optional feature macro: READ_ID_GATE_ERR_EN (sticky protocol error on err_o).
module read_id_gate
  import read_id_gate_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int unsigned ID_WIDTH        = DEFAULT_ID_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = 8,
  localparam int unsigned ID_COUNT       = 2 ** ID_WIDTH,
  localparam int unsigned CNT_WIDTH      = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   s_arid_i,
  input  logic                  s_arvalid_i,
  output logic                  s_arready_o,
  output logic [DATA_WIDTH-1:0] s_rdata_o,
  output logic [ID_WIDTH-1:0]   s_rid_o,
  output logic                  s_rvalid_o,
  input  logic                  s_rready_i,
  output logic [ID_WIDTH-1:0]   m_arid_o,
  output logic                  m_arvalid_o,
  input  logic                  m_arready_i,
  input  logic [DATA_WIDTH-1:0] m_rdata_i,
  input  logic [ID_WIDTH-1:0]   m_rid_i,
  input  logic                  m_rvalid_i,
  output logic                  m_rready_o,
  output logic [ID_COUNT-1:0]   busy_ids_o,
  output logic [CNT_WIDTH-1:0]  outstanding_o,
  output logic                  err_o
);

  logic                full_q;
  logic [ID_WIDTH-1:0] held_id_q;
  logic                slot_free_c;
  logic                room_c;
  logic                ar_ready_c;
  logic                ar_accept_c;
  logic                r_hs_c;
  logic [ID_COUNT-1:0] busy_c;

  // Admission: holding slot can take a new AR, the ID is idle and there is room.
  always_comb begin
    slot_free_c = !full_q || m_arready_i;
    ar_ready_c  = slot_free_c && !busy_c[s_arid_i] && room_c;
    ar_accept_c = s_arvalid_i && ar_ready_c;
    r_hs_c      = m_rvalid_i && s_rready_i;
  end

  // AR holding register: load on accept, drain when downstream takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= 1'b0;
      held_id_q <= '0;
    end else if (ar_accept_c) begin
      full_q    <= 1'b1;
      held_id_q <= s_arid_i;
    end else if (m_arready_i) begin
      full_q    <= 1'b0;
    end
  end

  id_scoreboard #(
    .ID_WIDTH        (ID_WIDTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_id_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_i    (ar_accept_c),
    .set_id_i (s_arid_i),
    .clr_i    (r_hs_c),
    .clr_id_i (m_rid_i),
    .busy_o   (busy_c),
    .count_o  (outstanding_o),
    .room_c   (room_c),
    .err_o    (err_o)
  );

  assign s_arready_o = ar_ready_c;
  assign m_arvalid_o = full_q;
  assign m_arid_o    = held_id_q;
  assign busy_ids_o  = busy_c;

  // R channel is a pure combinational passthrough.
  assign s_rdata_o  = m_rdata_i;
  assign s_rid_o    = m_rid_i;
  assign s_rvalid_o = m_rvalid_i;
  assign m_rready_o = s_rready_i;

endmodule : read_id_gate
